qupls_commit_head_advance: RTL and testbench

Downstream consumer of the commit-count stage. Owns the ROB head pointers head0..head5, which the commit-count logic reads combinationally. Each cycle it takes the commit decision (do_commit, cmtcnt) and registers a commit group (base index, count) for the RAT/free-list update port with a valid/ready handshake. It advances the head pointers by the committed count and keeps a retired-instruction counter.

---
 rtl/qupls_commit_head_advance_if.sv | 12 +
 rtl/qupls_commit_head_advance.sv | 136 +++++++++++++
 tb/tb_qupls_commit_head_advance.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qupls_commit_head_advance_if.sv
// Commit-group port from the head-advance stage to the RAT/free-list update.
interface qupls_commit_head_advance_if #(
  parameter int NDXW = 5
);
  logic            cmt_v;
  logic [NDXW-1:0] cmt_base;
  logic [2:0]      cmt_n;
  logic            rat_rdy;

  modport master (output cmt_v, cmt_base, cmt_n, input rat_rdy);
  modport slave  (input cmt_v, cmt_base, cmt_n, output rat_rdy);
endinterface

// File: rtl/qupls_commit_head_advance.sv
// ROB head owner: registers commit groups for the RAT and advances head0..head5; QUPLS_COMMIT_PERF_EN adds perf counters.
// Latency: 1 cycle from the commit decision to cmt_v and to the updated heads.
// Backpressure: holds the group while rat_rdy is low and raises cmt_stall; flush overrides everything.
module qupls_commit_head_advance #(
  parameter int ROB_ENTRIES = 32,
  parameter int NDXW        = $clog2(ROB_ENTRIES),
  parameter int RETW        = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  do_commit,
  input  logic [2:0]            cmtcnt,
  input  logic                  flush,
  input  logic [NDXW-1:0]       flush_head,
  qupls_commit_head_advance_if.master cmt,
  output logic                  cmt_stall,
  output logic [NDXW-1:0]       head0,
  output logic [NDXW-1:0]       head1,
  output logic [NDXW-1:0]       head2,
  output logic [NDXW-1:0]       head3,
  output logic [NDXW-1:0]       head4,
  output logic [NDXW-1:0]       head5,
  output logic [RETW-1:0]       retired,
  output logic                  err
`ifdef QUPLS_COMMIT_PERF_EN
  ,
  output logic [31:0]           stall_cyc,
  output logic [6:1][15:0]      grp_hist
`endif
);

  localparam logic [NDXW:0] ROB_N = (NDXW+1)'(ROB_ENTRIES);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NDXW-1:0] head0_q;
  logic [NDXW-1:0] base_q;
  logic [2:0]      n_q;
  logic [RETW-1:0] retired_q;
  logic            err_q;

  logic xfer, held, cnt_ok, accept, fh_oob, err_d;

  // k <= 6 < ROB_ENTRIES, so one conditional subtract brings the sum back in range
  function automatic logic [NDXW-1:0] wrap_add(input logic [NDXW-1:0] base, input logic [2:0] k);
    logic [NDXW:0] sum;
    sum = {1'b0, base} + {{(NDXW-2){1'b0}}, k};
    if (sum >= ROB_N)
      sum = sum - ROB_N;
    return sum[NDXW-1:0];
  endfunction

  assign xfer   = cmt.cmt_v && cmt.rat_rdy;
  assign held   = cmt.cmt_v && !cmt.rat_rdy;
  assign cnt_ok = (cmtcnt != 3'd0) && (cmtcnt != 3'd7);
  assign accept = do_commit && cnt_ok && !flush && (!cmt.cmt_v || cmt.rat_rdy);
  assign fh_oob = ({1'b0, flush_head} >= ROB_N);
  assign err_d  = err_q
                | (do_commit && held)
                | (do_commit && (cmtcnt == 3'd7))
                | (flush && fh_oob);

  // Commit-port state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = EMPTY;
    else if (accept)
      state_d = FULL;
    else if (xfer)
      state_d = EMPTY;
  end

  always_comb begin
    cmt.cmt_v = (state_q == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head0_q   <= '0;
      base_q    <= '0;
      n_q       <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      // A transfer in the flush cycle still completes and is counted
      if (xfer)
        retired_q <= retired_q + RETW'(n_q);
      if (flush) begin
        head0_q <= fh_oob ? '0 : flush_head;
      end else if (accept) begin
        head0_q <= wrap_add(head0_q, cmtcnt);
        base_q  <= head0_q;
        n_q     <= cmtcnt;
      end
    end
  end

  assign cmt.cmt_base = base_q;
  assign cmt.cmt_n    = n_q;
  assign cmt_stall    = held;
  assign head0        = head0_q;
  assign head1        = wrap_add(head0_q, 3'd1);
  assign head2        = wrap_add(head0_q, 3'd2);
  assign head3        = wrap_add(head0_q, 3'd3);
  assign head4        = wrap_add(head0_q, 3'd4);
  assign head5        = wrap_add(head0_q, 3'd5);
  assign retired      = retired_q;
  assign err          = err_q;

`ifdef QUPLS_COMMIT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc <= '0;
      grp_hist  <= '0;
    end else begin
      if (held && (stall_cyc != '1))
        stall_cyc <= stall_cyc + 32'd1;
      for (int g = 1; g <= 6; g++) begin
        if (xfer && (n_q == 3'(g)) && (grp_hist[g] != '1))
          grp_hist[g] <= grp_hist[g] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qupls_commit_head_advance.sv
// Directed bench for qupls_commit_head_advance: scoreboard on the commit port, direct checks on heads/counters.
module tb_qupls_commit_head_advance;

  localparam int NDXW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT, ROB_ENTRIES = 32
  logic            do_commit, flush;
  logic [2:0]      cmtcnt;
  logic [NDXW-1:0] flush_head;
  logic            cmt_stall;
  logic [NDXW-1:0] head0, head1, head2, head3, head4, head5;
  logic [39:0]     retired;
  logic            err;

  qupls_commit_head_advance_if #(.NDXW(NDXW)) cif ();

  // Second DUT, ROB_ENTRIES = 20, for non-power-of-two wrap and out-of-range flush
  logic            do2, flush2;
  logic [2:0]      cnt2;
  logic [NDXW-1:0] fh2;
  logic            stall2;
  logic [NDXW-1:0] h2_0, h2_1, h2_2, h2_3, h2_4, h2_5;
  logic [39:0]     ret2;
  logic            err2;

  qupls_commit_head_advance_if #(.NDXW(NDXW)) cif2 ();

`ifdef QUPLS_COMMIT_PERF_EN
  logic [31:0]      stall_cyc, stall_cyc2;
  logic [6:1][15:0] grp_hist, grp_hist2;
`endif

  qupls_commit_head_advance #(.ROB_ENTRIES(32), .RETW(40)) u_dut (
    .clk(clk), .rst_n(rst_n), .do_commit(do_commit), .cmtcnt(cmtcnt),
    .flush(flush), .flush_head(flush_head), .cmt(cif), .cmt_stall(cmt_stall),
    .head0(head0), .head1(head1), .head2(head2), .head3(head3), .head4(head4), .head5(head5),
    .retired(retired), .err(err)
`ifdef QUPLS_COMMIT_PERF_EN
    , .stall_cyc(stall_cyc), .grp_hist(grp_hist)
`endif
  );

  qupls_commit_head_advance #(.ROB_ENTRIES(20), .RETW(40)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .do_commit(do2), .cmtcnt(cnt2),
    .flush(flush2), .flush_head(fh2), .cmt(cif2), .cmt_stall(stall2),
    .head0(h2_0), .head1(h2_1), .head2(h2_2), .head3(h2_3), .head4(h2_4), .head5(h2_5),
    .retired(ret2), .err(err2)
`ifdef QUPLS_COMMIT_PERF_EN
    , .stall_cyc(stall_cyc2), .grp_hist(grp_hist2)
`endif
  );

  int vecs = 0;
  int miss = 0;

  typedef struct packed {
    logic [NDXW-1:0] base;
    logic [2:0]      n;
  } grp_t;
  grp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every transfer on the main commit port must match the next queued group
  always @(negedge clk) begin
    if (rst_n && cif.cmt_v && cif.rat_rdy) begin
      if (sb_q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL sb_unexpected: got base %0d n %0d expected no transfer",
                 cif.cmt_base, cif.cmt_n);
      end else begin
        grp_t e;
        e = sb_q.pop_front();
        chk("sb_base", 64'(cif.cmt_base), 64'(e.base));
        chk("sb_n",    64'(cif.cmt_n),    64'(e.n));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int b, input int n);
    grp_t e;
    e.base = NDXW'(b);
    e.n    = 3'(n);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    do_commit = 1'b0; cmtcnt = 3'd0; flush = 1'b0; flush_head = '0; cif.rat_rdy = 1'b1;
    do2 = 1'b0; cnt2 = 3'd0; flush2 = 1'b0; fh2 = '0; cif2.rat_rdy = 1'b1;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    do_reset();

    // Reset state
    chk("rst_head0", 64'(head0), 0);
    chk("rst_head1", 64'(head1), 1);
    chk("rst_head2", 64'(head2), 2);
    chk("rst_head3", 64'(head3), 3);
    chk("rst_head4", 64'(head4), 4);
    chk("rst_head5", 64'(head5), 5);
    chk("rst_cmt_v", 64'(cif.cmt_v), 0);
    chk("rst_base",  64'(cif.cmt_base), 0);
    chk("rst_n",     64'(cif.cmt_n), 0);
    chk("rst_ret",   retired, 0);
    chk("rst_err",   64'(err), 0);

    // Move head to 28, then back-to-back accepts across the wrap
    flush = 1'b1; flush_head = 5'd28;
    cyc();
    flush = 1'b0;
    chk("fl28_head0", 64'(head0), 28);
    chk("fl28_head5", 64'(head5), 1);
    do_commit = 1'b1; cmtcnt = 3'd6; push(28, 6);
    cyc();
    chk("acc1_v",     64'(cif.cmt_v), 1);
    chk("acc1_head0", 64'(head0), 2);
    chk("acc1_head5", 64'(head5), 7);
    cmtcnt = 3'd3; push(2, 3);
    cyc();
    chk("acc2_v",     64'(cif.cmt_v), 1);
    chk("acc2_head0", 64'(head0), 5);
    chk("acc2_ret",   retired, 6);
    do_commit = 1'b0;
    cyc();
    chk("acc_done_v",   64'(cif.cmt_v), 0);
    chk("acc_done_ret", retired, 9);

    // Legal idle commit
    do_commit = 1'b1; cmtcnt = 3'd0;
    cyc();
    do_commit = 1'b0;
    chk("idle_v",     64'(cif.cmt_v), 0);
    chk("idle_head0", 64'(head0), 5);
    chk("idle_err",   64'(err), 0);

    // Hold for 3 cycles
    do_commit = 1'b1; cmtcnt = 3'd4; cif.rat_rdy = 1'b0; push(5, 4);
    cyc();
    do_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", 64'(cmt_stall), 1);
      chk("hold_v",     64'(cif.cmt_v), 1);
      chk("hold_base",  64'(cif.cmt_base), 5);
      chk("hold_n",     64'(cif.cmt_n), 4);
      chk("hold_head0", 64'(head0), 9);
      cyc();
    end
    cif.rat_rdy = 1'b1;
    cyc();
    chk("hold_rel_v",   64'(cif.cmt_v), 0);
    chk("hold_rel_ret", retired, 13);
    chk("hold_err",     64'(err), 0);

    // Flush discards a held group
    do_commit = 1'b1; cmtcnt = 3'd1; cif.rat_rdy = 1'b0;
    cyc();
    do_commit = 1'b0; flush = 1'b1; flush_head = 5'd17;
    cyc();
    flush = 1'b0; cif.rat_rdy = 1'b1;
    chk("flh_head0", 64'(head0), 17);
    chk("flh_head5", 64'(head5), 22);
    chk("flh_v",     64'(cif.cmt_v), 0);
    chk("flh_ret",   retired, 13);

    // Transfer, flush and do_commit in the same cycle
    do_commit = 1'b1; cmtcnt = 3'd3; cif.rat_rdy = 1'b0; push(17, 3);
    cyc();
    chk("sim_pre_head0", 64'(head0), 20);
    cif.rat_rdy = 1'b1; flush = 1'b1; flush_head = 5'd4; cmtcnt = 3'd2;
    cyc();
    flush = 1'b0; do_commit = 1'b0;
    chk("sim_ret",   retired, 16);
    chk("sim_v",     64'(cif.cmt_v), 0);
    chk("sim_head0", 64'(head0), 4);
    chk("sim_err",   64'(err), 0);

    // cmtcnt = 7 is rejected and flagged
    do_commit = 1'b1; cmtcnt = 3'd7;
    cyc();
    do_commit = 1'b0;
    chk("c7_v",     64'(cif.cmt_v), 0);
    chk("c7_head0", 64'(head0), 4);
    chk("c7_err",   64'(err), 1);

    // do_commit during a hold
    do_reset();
    chk("rst2_err", 64'(err), 0);
    do_commit = 1'b1; cmtcnt = 3'd2; cif.rat_rdy = 1'b0; push(0, 2);
    cyc();
    cmtcnt = 3'd3;
    cyc();
    chk("hviol_err",   64'(err), 1);
    chk("hviol_head0", 64'(head0), 2);
    chk("hviol_base",  64'(cif.cmt_base), 0);
    chk("hviol_n",     64'(cif.cmt_n), 2);
    do_commit = 1'b0; cif.rat_rdy = 1'b1;
    cyc();
    chk("hviol_ret", retired, 2);
    chk("hviol_v",   64'(cif.cmt_v), 0);

    // 5 stall cycles, then transfers of sizes 1, 1, 6
    do_reset();
    do_commit = 1'b1; cmtcnt = 3'd1; cif.rat_rdy = 1'b0; push(0, 1);
    cyc();
    do_commit = 1'b0;
    repeat (5) cyc();
    cif.rat_rdy = 1'b1; do_commit = 1'b1; cmtcnt = 3'd1; push(1, 1);
    cyc();
    cmtcnt = 3'd6; push(2, 6);
    cyc();
    do_commit = 1'b0;
    cyc();
    chk("perf_ret",   retired, 8);
    chk("perf_head0", 64'(head0), 8);
    chk("perf_v",     64'(cif.cmt_v), 0);
`ifdef QUPLS_COMMIT_PERF_EN
    chk("perf_stall", 64'(stall_cyc), 5);
    chk("perf_h1",    64'(grp_hist[1]), 2);
    chk("perf_h6",    64'(grp_hist[6]), 1);
    chk("perf_h3",    64'(grp_hist[3]), 0);
`endif

    // ROB_ENTRIES = 20: wrap and out-of-range flush
    flush2 = 1'b1; fh2 = 5'd17;
    cyc();
    flush2 = 1'b0;
    chk("r20_head0", 64'(h2_0), 17);
    chk("r20_head1", 64'(h2_1), 18);
    chk("r20_head3", 64'(h2_3), 0);
    chk("r20_head5", 64'(h2_5), 2);
    do2 = 1'b1; cnt2 = 3'd6;
    cyc();
    do2 = 1'b0;
    chk("r20_v",     64'(cif2.cmt_v), 1);
    chk("r20_base",  64'(cif2.cmt_base), 17);
    chk("r20_acc_head0", 64'(h2_0), 3);
    chk("r20_stall", 64'(stall2), 0);
    flush2 = 1'b1; fh2 = 5'd25;
    cyc();
    flush2 = 1'b0;
    chk("r20_oob_head0", 64'(h2_0), 0);
    chk("r20_oob_head4", 64'(h2_4), 4);
    chk("r20_oob_err",   64'(err2), 1);
    chk("r20_oob_ret",   ret2, 6);
    chk("r20_oob_v",     64'(cif2.cmt_v), 0);

    cyc();
    chk("sb_drained", 64'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
